// File: rtl/branch_resolve_if.sv
// Handshake and result bundle between decode, the branch resolve stage, writeback and ifetch.
interface branch_resolve_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            in_epoch;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_next_pc;
    logic            out_taken;
    logic [XLEN-1:0] out_rd_value;
    logic            out_exc;
    logic [3:0]      out_exc_cause;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_epoch;

    modport master (
        output in_valid, in_pc, in_instr, in_rs1_data, in_rs2_data, in_epoch, out_ready,
        input  in_ready, out_valid, out_pc, out_next_pc, out_taken, out_rd_value,
               out_exc, out_exc_cause, redirect_valid, redirect_pc, redirect_epoch
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_rs1_data, in_rs2_data, in_epoch, out_ready,
        output in_ready, out_valid, out_pc, out_next_pc, out_taken, out_rd_value,
               out_exc, out_exc_cause, redirect_valid, redirect_pc, redirect_epoch
    );
endinterface

// File: rtl/branch_resolve_stage.sv
// Resolves conditional branches, JAL and JALR; registers the result and pulses a fetch
// redirect on taken transfers, squashing wrong-path instructions via an epoch bit.
module branch_resolve_stage #(
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic            epoch;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] b_imm, j_imm, i_imm;
    logic [XLEN-1:0] pc_plus4, target, next_pc, rd_value;
    logic            taken, is_jump, illegal, misaligned, exc;
    logic [3:0]      cause;
    logic            accept, fresh, do_redirect;

    assign opcode   = bus.in_instr[6:0];
    assign funct3   = bus.in_instr[14:12];
    assign b_imm    = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                       bus.in_instr[11:8], 1'b0};
    assign j_imm    = {{(XLEN-20){bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                       bus.in_instr[30:21], 1'b0};
    assign i_imm    = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign pc_plus4 = bus.in_pc + XLEN'(4);

    always_comb begin
        taken   = 1'b0;
        is_jump = 1'b0;
        illegal = 1'b0;
        target  = bus.in_pc + b_imm;
        unique case (opcode)
            OP_BRANCH: begin
                unique case (funct3)
                    3'b000:  taken = (bus.in_rs1_data == bus.in_rs2_data);
                    3'b001:  taken = (bus.in_rs1_data != bus.in_rs2_data);
                    3'b100:  taken = ($signed(bus.in_rs1_data) <  $signed(bus.in_rs2_data));
                    3'b101:  taken = ($signed(bus.in_rs1_data) >= $signed(bus.in_rs2_data));
                    3'b110:  taken = (bus.in_rs1_data <  bus.in_rs2_data);
                    3'b111:  taken = (bus.in_rs1_data >= bus.in_rs2_data);
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                taken   = 1'b1;
                is_jump = 1'b1;
                target  = bus.in_pc + j_imm;
            end
            OP_JALR: begin
                taken   = 1'b1;
                is_jump = 1'b1;
                target  = (bus.in_rs1_data + i_imm) & ~XLEN'(1);
            end
            default: ;
        endcase
    end

    // A misaligned taken target reports the fault but never steers fetch.
    assign misaligned  = taken && (target[1:0] != 2'b00);
    assign exc         = illegal || misaligned;
    assign cause       = misaligned ? 4'd0 : 4'd2;
    assign next_pc     = taken ? target : pc_plus4;
    assign rd_value    = (is_jump && !misaligned) ? pc_plus4 : '0;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fresh        = accept && (bus.in_epoch == epoch);
    assign do_redirect  = fresh && taken && !misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            epoch              <= 1'b0;
            bus.out_valid      <= 1'b0;
            bus.out_pc         <= '0;
            bus.out_next_pc    <= '0;
            bus.out_taken      <= 1'b0;
            bus.out_rd_value   <= '0;
            bus.out_exc        <= 1'b0;
            bus.out_exc_cause  <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.redirect_epoch <= 1'b0;
        end else begin
            bus.redirect_valid <= 1'b0;
            if (bus.out_ready)
                bus.out_valid <= 1'b0;
            if (fresh) begin
                bus.out_valid     <= 1'b1;
                bus.out_pc        <= bus.in_pc;
                bus.out_next_pc   <= next_pc;
                bus.out_taken     <= taken;
                bus.out_rd_value  <= rd_value;
                bus.out_exc       <= exc;
                bus.out_exc_cause <= exc ? cause : 4'd0;
            end
            if (do_redirect) begin
                bus.redirect_valid <= 1'b1;
                bus.redirect_pc    <= target;
                bus.redirect_epoch <= ~epoch;
                epoch              <= ~epoch;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed-vector bench: the driver queues hand-computed results and redirects, monitors compare.
module tb_branch_resolve_stage;
    localparam int XLEN = 64;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] next_pc;
        logic [63:0] rd;
        logic        taken;
        logic        exc;
        logic [3:0]  cause;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic        epoch;
    } red_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    red_t red_q[$];

    branch_resolve_if #(.XLEN(XLEN)) bus ();

    branch_resolve_stage #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] nxt, input logic tk,
                                input logic [63:0] rd, input logic ex, input logic [3:0] cs);
        exp_t e;
        e.pc = pc; e.next_pc = nxt; e.taken = tk; e.rd = rd; e.exc = ex; e.cause = cs;
        return e;
    endfunction

    // Drive one instruction until accepted; expectations are queued at issue time.
    task automatic send(input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic ep, input bit has_out, input exp_t e,
                        input bit has_red, input logic [63:0] rpc, input logic rep);
        red_t r;
        bit   done = 0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_instr    = instr;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        bus.in_epoch    = ep;
        if (has_out) exp_q.push_back(e);
        if (has_red) begin
            r.pc = rpc; r.epoch = rep;
            red_q.push_back(r);
        end
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        #1 bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_pc",        bus.out_pc,                e.pc);
                chk("out_next_pc",   bus.out_next_pc,           e.next_pc);
                chk("out_taken",     {63'd0, bus.out_taken},    {63'd0, e.taken});
                chk("out_rd_value",  bus.out_rd_value,          e.rd);
                chk("out_exc",       {63'd0, bus.out_exc},      {63'd0, e.exc});
                chk("out_exc_cause", {60'd0, bus.out_exc_cause}, {60'd0, e.cause});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.redirect_valid) begin
            if (red_q.size() == 0) begin
                chk("unexpected_redirect", {63'd0, bus.redirect_valid}, 64'd0);
            end else begin
                red_t r;
                r = red_q.pop_front();
                chk("redirect_pc",    bus.redirect_pc,                r.pc);
                chk("redirect_epoch", {63'd0, bus.redirect_epoch},    {63'd0, r.epoch});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [63:0] A = 64'h11223344AADDEEFF;
    localparam logic [63:0] B = 64'h99331144BBCC00EE;
    localparam logic [31:0] NOP = 32'h00000013;

    initial begin
        exp_t e0;
        int   red_cnt;
        e0 = mk(0, 0, 0, 0, 0, 0);
        bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0;
        bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_epoch = 0; bus.out_ready = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",      {63'd0, bus.out_valid},      64'd0);
        chk("rst_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst_in_ready",       {63'd0, bus.in_ready},       64'd1);
        chk("rst_out_next_pc",    bus.out_next_pc,             64'd0);
        rst = 0;

        send(64'h20,  32'h00208463, A, B, 0, 1, mk(64'h20, 64'h24, 0, 0, 0, 0), 0, 0, 0);
        send(64'h100, 32'h0020C463, B, A, 0, 1, mk(64'h100, 64'h108, 1, 0, 0, 0), 1, 64'h108, 1);
        send(64'h200, 32'h0020E463, A, B, 1, 1, mk(64'h200, 64'h208, 1, 0, 0, 0), 1, 64'h208, 0);
        send(64'h300, 32'h0020D463, B, A, 0, 1, mk(64'h300, 64'h304, 0, 0, 0, 0), 0, 0, 0);
        send(64'h400, 32'h02000067, 0, 0, 0, 1, mk(64'h400, 64'h20, 1, 64'h404, 0, 0), 1, 64'h20, 1);
        send(64'h0,   32'hFFDFF06F, 0, 0, 1, 1,
             mk(64'h0, 64'hFFFFFFFFFFFFFFFC, 1, 64'h4, 0, 0), 1, 64'hFFFFFFFFFFFFFFFC, 0);

        // Taken BEQ followed by wrong-path instructions still tagged with the old epoch.
        send(64'h500, 32'h00208463, 64'd5, 64'd5, 0, 1, mk(64'h500, 64'h508, 1, 0, 0, 0), 1, 64'h508, 1);
        send(64'h504, 32'h00000033, 0, 0, 0, 0, e0, 0, 0, 0);
        send(64'h508, 32'h00208463, 64'd5, 64'd5, 0, 0, e0, 0, 0, 0);
        send(64'h50C, 32'h02000067, 0, 0, 0, 0, e0, 0, 0, 0);
        send(64'h508, NOP, 0, 0, 1, 1, mk(64'h508, 64'h50C, 0, 0, 0, 0), 0, 0, 0);

        send(64'h600, 32'h0020A463, A, B, 1, 1, mk(64'h600, 64'h604, 0, 0, 1, 4'd2), 0, 0, 0);

        // Downstream stall after a taken BNE.
        repeat (2) @(negedge clk);
        bus.out_ready = 0;
        send(64'h700, 32'h00209463, A, B, 1, 1, mk(64'h700, 64'h708, 1, 0, 0, 0), 1, 64'h708, 0);
        red_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.redirect_valid) red_cnt++;
            chk("stall_out_valid",   {63'd0, bus.out_valid}, 64'd1);
            chk("stall_out_next_pc", bus.out_next_pc,        64'h708);
            chk("stall_out_taken",   {63'd0, bus.out_taken}, 64'd1);
            chk("stall_in_ready",    {63'd0, bus.in_ready},  64'd0);
        end
        chk("stall_redirect_count", 64'(red_cnt), 64'd1);
        bus.out_ready = 1;

        send(64'h800, 32'h00008067, 64'h22, 0, 0, 1, mk(64'h800, 64'h22, 1, 0, 1, 4'd0), 0, 0, 0);
        send(64'h900, 32'h00008067, 64'h31, 0, 0, 1, mk(64'h900, 64'h30, 1, 64'h904, 0, 0), 1, 64'h30, 1);

        // Reset while a result is held must drop it and restore epoch 0.
        repeat (3) @(negedge clk);
        bus.out_ready = 0;
        send(64'hA00, NOP, 0, 0, 1, 0, e0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_out_valid",      {63'd0, bus.out_valid},      64'd0);
        chk("midrst_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("midrst_out_pc",         bus.out_pc,                  64'd0);
        rst = 0;
        bus.out_ready = 1;
        send(64'hB00, NOP, 0, 0, 0, 1, mk(64'hB00, 64'hB04, 0, 0, 0, 0), 0, 0, 0);

        for (int i = 0; i < 20 && (exp_q.size() != 0 || red_q.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("pending_outputs",   64'(exp_q.size()), 64'd0);
        chk("pending_redirects", 64'(red_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
